// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: size encoding, FSM states,
// requester count and the alignment check.
package dmem_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMerge,
    StResp
  } state_e;

  // True for any request that must not touch memory: misaligned half/word or illegal size.
  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    logic bad;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake plus data-memory port of the arbiter. The arbiter uses the slave
// modport; requesters and memory together form the master side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import dmem_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*32-1:0]     req_wdata;
  logic [NREQ*2-1:0]      req_size;
  logic [NREQ-1:0]        req_unsigned;
  logic [NREQ-1:0]        rsp_valid;
  logic [31:0]            rsp_data;
  logic                   rsp_err;
  logic [ADDR_W-1:0]      mem_address;
  logic [31:0]            mem_write_data;
  logic                   mem_write_enable;
  logic [31:0]            mem_read_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_address, mem_write_data,
           mem_write_enable
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_address, mem_write_data,
           mem_write_enable
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and store merge
// of right-aligned write data into an old memory word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] load_word_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = load_word_i >> {addr_lo_i, 3'b000};
    load_data_o = 32'h0;
    unique case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_data_o = load_word_i;
      default: load_data_o = 32'h0;
    endcase
  end

  always_comb begin
    merge_data_o = old_word_i;
    unique case (size_i)
      SZ_BYTE: merge_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_WORD: merge_data_o = wdata_i;
      default: merge_data_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of the single-port data memory. Each accepted request runs
// as one memory cycle (load, word store, error) or two (sub-word read-modify-write).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       old_q, old_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic              gnt;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_write_enable;

  dmem_lane_align u_lane_align (
    .load_word_i  (bus.mem_read_data),
    .old_word_i   (old_q),
    .wdata_i      (wdata_q),
    .addr_lo_i    (addr_q[1:0]),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  // On a tie the requester not granted last wins; a lone requester always wins.
  assign gnt = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    owner_d          = owner_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    size_d           = size_q;
    uns_d            = uns_q;
    old_d            = old_q;
    data_d           = data_q;
    err_d            = err_q;
    req_ready        = '0;
    rsp_valid        = '0;
    rsp_data         = 32'h0;
    rsp_err          = 1'b0;
    mem_address      = '0;
    mem_write_data   = 32'h0;
    mem_write_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid != '0) begin
          req_ready[gnt] = 1'b1;
          owner_d = gnt;
          we_d    = bus.req_we[gnt];
          addr_d  = gnt ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
          wdata_d = gnt ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
          size_d  = size_e'(gnt ? bus.req_size[3:2] : bus.req_size[1:0]);
          uns_d   = bus.req_unsigned[gnt];
          data_d  = 32'h0;
          err_d   = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        mem_address = {addr_q[ADDR_W-1:2], 2'b00};
        if (is_misaligned(size_q, addr_q[1:0])) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (!we_q) begin
          data_d  = load_data;
          state_d = StResp;
        end else if (size_q == SZ_WORD) begin
          mem_write_enable = 1'b1;
          mem_write_data   = wdata_q;
          state_d          = StResp;
        end else begin
          old_d   = bus.mem_read_data;
          state_d = StMerge;
        end
      end
      StMerge: begin
        mem_address      = {addr_q[ADDR_W-1:2], 2'b00};
        mem_write_enable = 1'b1;
        mem_write_data   = merge_data;
        state_d          = StResp;
      end
      StResp: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_data           = data_q;
        rsp_err            = err_q;
        last_d             = owner_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      old_q   <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      old_q   <= old_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.rsp_valid        = rsp_valid;
  assign bus.rsp_data         = rsp_data;
  assign bus.rsp_err          = rsp_err;
  assign bus.mem_address      = mem_address;
  assign bus.mem_write_data   = mem_write_data;
  assign bus.mem_write_enable = mem_write_enable;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: word/byte/half access, error cases, reset during a
// read-modify-write and round-robin alternation, against a small word memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   t_acc, w_acc;
  logic [31:0] mem [256];

  logic [31:0] r_data;
  logic        r_err;
  logic [1:0]  r_valid;
  int          r_lat, r_wr;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_write_enable) begin
      mem[bus.mem_address[9:2]] <= bus.mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
    end
  endtask

  // Presents a request on requester r and returns at the falling edge after the handshake.
  task automatic accept(input string tag, input int r, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic un);
    bit got = 1'b0;
    @(negedge clk);
    bus.req_we[r]             = we;
    bus.req_addr[r*32 +: 32]  = a;
    bus.req_wdata[r*32 +: 32] = wd;
    bus.req_size[r*2 +: 2]    = sz;
    bus.req_unsigned[r]       = un;
    bus.req_valid[r]          = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready[r]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, "accept", 32'(got), 32'd1);
    t_acc = cyc;
    w_acc = wr_cnt;
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.rsp_valid != 2'b00) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, "rsp_seen", 32'(got), 32'd1);
    r_lat   = cyc - t_acc;
    r_wr    = wr_cnt - w_acc;
    r_valid = bus.rsp_valid;
    r_data  = bus.rsp_data;
    r_err   = bus.rsp_err;
  endtask

  task automatic op(input string tag, input int r, input logic we, input logic [31:0] a,
                    input logic [31:0] wd, input logic [1:0] sz, input logic un,
                    input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                    input int exp_wr);
    logic [1:0] exp_v;
    exp_v = (r == 0) ? 2'b01 : 2'b10;
    accept(tag, r, we, a, wd, sz, un);
    wait_rsp(tag);
    chk(tag, "latency", 32'(r_lat), 32'(exp_lat));
    chk(tag, "rsp_valid", 32'(r_valid), 32'(exp_v));
    chk(tag, "rsp_data", r_data, exp_d);
    chk(tag, "rsp_err", 32'(r_err), 32'(exp_e));
    chk(tag, "strobes", 32'(r_wr), 32'(exp_wr));
  endtask

  initial begin
    logic [1:0] exp_g;
    bit         got;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[65] = 32'hCAFEF00D;
    bus.req_valid    = 2'b00;
    bus.req_we       = 2'b00;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 2'b00;

    repeat (3) @(negedge clk);
    chk("reset", "req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset", "rsp_data", bus.rsp_data, 32'd0);
    chk("reset", "mem_we", 32'(bus.mem_write_enable), 32'd0);
    chk("reset", "mem_addr", bus.mem_address, 32'd0);
    rst_n = 1'b1;

    op("sw", 0, 1'b1, 32'h100, 32'hDEADBEEF, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 1);
    chk("sw", "mem", mem[64], 32'hDEADBEEF);
    op("lw", 0, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 2, 0);

    op("sb", 0, 1'b1, 32'h101, 32'h000000AA, SZ_BYTE, 1'b0, 32'h0, 1'b0, 3, 1);
    chk("sb", "mem", mem[64], 32'hDEADAAEF);
    op("lbu", 1, 1'b0, 32'h101, 32'h0, SZ_BYTE, 1'b1, 32'h000000AA, 1'b0, 2, 0);
    op("lb", 0, 1'b0, 32'h101, 32'h0, SZ_BYTE, 1'b0, 32'hFFFFFFAA, 1'b0, 2, 0);

    op("sh", 1, 1'b1, 32'h102, 32'h00001234, SZ_HALF, 1'b0, 32'h0, 1'b0, 3, 1);
    chk("sh", "mem", mem[64], 32'h1234AAEF);
    op("lh_hi", 0, 1'b0, 32'h102, 32'h0, SZ_HALF, 1'b0, 32'h00001234, 1'b0, 2, 0);
    op("lh_lo", 0, 1'b0, 32'h100, 32'h0, SZ_HALF, 1'b0, 32'hFFFFAAEF, 1'b0, 2, 0);
    op("lbu3", 0, 1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b1, 32'h00000012, 1'b0, 2, 0);

    op("lh_mis", 0, 1'b0, 32'h103, 32'h0, SZ_HALF, 1'b0, 32'h0, 1'b1, 2, 0);
    op("lw_mis", 1, 1'b0, 32'h102, 32'h0, SZ_WORD, 1'b0, 32'h0, 1'b1, 2, 0);
    op("ill", 0, 1'b0, 32'h100, 32'h0, SZ_ILL, 1'b0, 32'h0, 1'b1, 2, 0);
    op("sw_mis", 0, 1'b1, 32'h102, 32'h55555555, SZ_WORD, 1'b0, 32'h0, 1'b1, 2, 0);
    op("sh_mis", 1, 1'b1, 32'h101, 32'h5555, SZ_HALF, 1'b0, 32'h0, 1'b1, 2, 0);
    chk("err", "mem", mem[64], 32'h1234AAEF);

    // Reset in the middle of the read-modify-write cycle.
    accept("rst", 0, 1'b1, 32'h100, 32'h00000055, SZ_BYTE, 1'b0);
    @(negedge clk);
    #1;
    chk("rst", "we_in_merge", 32'(bus.mem_write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst", "we_async", 32'(bus.mem_write_enable), 32'd0);
    chk("rst", "mem_addr", bus.mem_address, 32'd0);
    chk("rst", "mem_wdata", bus.mem_write_data, 32'd0);
    chk("rst", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst", "rsp_data", bus.rsp_data, 32'd0);
    chk("rst", "rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    #1;
    chk("rst", "mem_kept", mem[64], 32'h1234AAEF);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held valid: grants alternate starting with requester 0.
    @(negedge clk);
    bus.req_we       = 2'b00;
    bus.req_addr     = {32'h104, 32'h100};
    bus.req_size     = {SZ_WORD, SZ_WORD};
    bus.req_unsigned = 2'b00;
    bus.req_valid    = 2'b11;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (bus.req_ready != 2'b00) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rr", "accept", 32'(got), 32'd1);
      chk("rr", "grant", 32'(bus.req_ready), 32'(exp_g));
      t_acc = cyc;
      w_acc = wr_cnt;
      @(negedge clk);
      wait_rsp("rr");
      chk("rr", "rsp_valid", 32'(r_valid), 32'(exp_g));
      chk("rr", "rsp_data", r_data, (k % 2 == 0) ? 32'h1234AAEF : 32'hCAFEF00D);
      chk("rr", "latency", 32'(r_lat), 32'd2);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
